cpu_ad48_csr_file: RTL and testbench

Control/status register file for the cpu_ad48 core. It is the stage downstream of instruction decode and consumes decoded CSR requests: read, read-write, read-set and read-clear.
- Holds STATUS, SCRATCH, CYCLE and INSTRET.
- Returns the old CSR value one cycle after each request.
- Exports the current privilege mode, taken from STATUS[1:0].

---
 rtl/cpu_ad48_csr_file.sv | 119 +++++++++++
 tb/tb_cpu_ad48_csr_file.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ad48_csr_file.sv
// cpu_ad48_csr_file: control/status register file for the cpu_ad48 core.
// Holds STATUS, SCRATCH, CYCLE and INSTRET. It consumes decoded CSR requests
// (R / RW / RS / RC) and returns the pre-update CSR value one cycle later.
//
// Handshake: req_valid has no ready. A request is accepted on every rising
// edge where req_valid=1 and resetn=1, back-to-back every cycle allowed.
// resp_valid pulses exactly one cycle after each accepted request.
// resp_rdata/resp_illegal are qualified by resp_valid and hold while it is low.
module cpu_ad48_csr_file #(
    parameter int              XLEN         = 48,
    parameter logic [11:0]     ADDR_STATUS  = 12'h300,
    parameter logic [11:0]     ADDR_SCRATCH = 12'h340,
    parameter logic [11:0]     ADDR_CYCLE   = 12'hC00,
    parameter logic [11:0]     ADDR_INSTRET = 12'hC02,
    parameter logic [XLEN-1:0] STATUS_RESET = XLEN'(3)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            retire,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic [XLEN-1:0] csr_status,
    output logic [1:0]      priv_mode,
    output logic [XLEN-1:0] csr_cycle,
    output logic [XLEN-1:0] csr_instret
);

    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic [XLEN-1:0] status_q;
    logic [XLEN-1:0] scratch_q;
    logic [XLEN-1:0] cycle_q;
    logic [XLEN-1:0] instret_q;

    logic            hit_status;
    logic            hit_scratch;
    logic            hit_cycle;
    logic            hit_instret;
    logic            req_illegal;
    logic            do_write;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_val;

    assign hit_status  = (req_addr == ADDR_STATUS);
    assign hit_scratch = (req_addr == ADDR_SCRATCH);
    assign hit_cycle   = (req_addr == ADDR_CYCLE);
    assign hit_instret = (req_addr == ADDR_INSTRET);

    // Unknown address, or any modifying op aimed at a read-only counter.
    assign req_illegal = ~(hit_status | hit_scratch | hit_cycle | hit_instret)
                       | ((hit_cycle | hit_instret) & (req_op != OP_R));

    // RS/RC with a zero mask still "write", but the value is unchanged.
    assign do_write = req_valid & ~req_illegal & (req_op != OP_R);

    // Select the current (pre-update) value of the addressed CSR.
    always_comb begin
        rd_val = '0;
        if (hit_status)       rd_val = status_q;
        else if (hit_scratch) rd_val = scratch_q;
        else if (hit_cycle)   rd_val = cycle_q;
        else if (hit_instret) rd_val = instret_q;
    end

    // Compute the post-update value for the writable CSRs.
    always_comb begin
        wr_val = rd_val;
        case (req_op)
            OP_RW:   wr_val = req_wdata;
            OP_RS:   wr_val = rd_val | req_wdata;
            OP_RC:   wr_val = rd_val & ~req_wdata;
            default: wr_val = rd_val;
        endcase
    end

    // CSR state: writable registers plus the two free-running counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_q  <= STATUS_RESET;
            scratch_q <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + XLEN'(1);
            if (retire) instret_q <= instret_q + XLEN'(1);
            if (do_write && hit_status)  status_q  <= wr_val;
            if (do_write && hit_scratch) scratch_q <= wr_val;
        end
    end

    // Response register: one-cycle latency, data held while no response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                resp_rdata   <= req_illegal ? '0 : rd_val;
                resp_illegal <= req_illegal;
            end
        end
    end

    assign csr_status  = status_q;
    assign priv_mode   = status_q[1:0];
    assign csr_cycle   = cycle_q;
    assign csr_instret = instret_q;

endmodule

// File: tb/tb_cpu_ad48_csr_file.sv
// Directed testbench for cpu_ad48_csr_file: inputs driven and outputs
// checked on the falling edge, one request per cycle.
module tb_cpu_ad48_csr_file;

    localparam int XLEN = 48;
    localparam logic [1:0] OP_R  = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;
    localparam logic [11:0] A_STATUS  = 12'h300;
    localparam logic [11:0] A_SCRATCH = 12'h340;
    localparam logic [11:0] A_CYCLE   = 12'hC00;
    localparam logic [11:0] A_INSTRET = 12'hC02;

    logic            clk;
    logic            resetn;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            retire;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_illegal;
    logic [XLEN-1:0] csr_status;
    logic [1:0]      priv_mode;
    logic [XLEN-1:0] csr_cycle;
    logic [XLEN-1:0] csr_instret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] c1;
    logic [XLEN-1:0] c2;
    logic [XLEN-1:0] cy;

    cpu_ad48_csr_file dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .retire       (retire),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .csr_status   (csr_status),
        .priv_mode    (priv_mode),
        .csr_cycle    (csr_cycle),
        .csr_instret  (csr_instret)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs (called at a falling edge), then wait
    // for the next falling edge so the response is visible.
    task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] addr,
                         input logic [XLEN-1:0] wdata, input logic ret);
        req_valid = v;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        retire    = ret;
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] wdata);
        drive(1'b1, op, addr, wdata, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, OP_R, 12'h000, '0, 1'b0);
    endtask

    task automatic check_resp(input string tag, input logic [XLEN-1:0] data, input logic ill);
        check({tag, "_valid"}, XLEN'(resp_valid), XLEN'(1));
        check({tag, "_rdata"}, resp_rdata, data);
        check({tag, "_illegal"}, XLEN'(resp_illegal), XLEN'(ill));
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_R;
        req_addr  = '0;
        req_wdata = '0;
        retire    = 1'b0;

        // 1. Reset for 4 cycles, then read STATUS.
        repeat (4) @(negedge clk);
        check("rst_resp_valid", XLEN'(resp_valid), XLEN'(0));
        check("rst_status", csr_status, XLEN'(3));
        check("rst_cycle", csr_cycle, '0);
        check("rst_instret", csr_instret, '0);
        resetn = 1'b1;
        req(OP_R, A_STATUS, '0);
        check_resp("r_status", XLEN'(3), 1'b0);
        check("priv_reset", XLEN'(priv_mode), XLEN'(2'b11));
        idle();
        check("idle_valid", XLEN'(resp_valid), XLEN'(0));
        check("idle_hold", resp_rdata, XLEN'(3));

        // 2. SCRATCH back-to-back sequence.
        req(OP_RW, A_SCRATCH, XLEN'(48'h12340));
        check_resp("rw_scratch", '0, 1'b0);
        req(OP_RS, A_SCRATCH, XLEN'(48'h000F));
        check_resp("rs_scratch", XLEN'(48'h12340), 1'b0);
        req(OP_R, A_SCRATCH, '0);
        check_resp("r_scratch1", XLEN'(48'h1234F), 1'b0);
        req(OP_RC, A_SCRATCH, XLEN'(48'h000F));
        check_resp("rc_scratch", XLEN'(48'h1234F), 1'b0);
        req(OP_R, A_SCRATCH, '0);
        check_resp("r_scratch2", XLEN'(48'h12340), 1'b0);
        req(OP_RS, A_SCRATCH, '0);
        check_resp("rs_zero", XLEN'(48'h12340), 1'b0);
        req(OP_RC, A_SCRATCH, '0);
        check_resp("rc_zero", XLEN'(48'h12340), 1'b0);
        req(OP_R, A_SCRATCH, '0);
        check_resp("r_scratch3", XLEN'(48'h12340), 1'b0);

        // 3. CYCLE delta and INSTRET counting.
        req(OP_R, A_CYCLE, '0);
        c1 = resp_rdata;
        idle();
        idle();
        req(OP_R, A_CYCLE, '0);
        c2 = resp_rdata;
        check("cycle_delta", c2 - c1, XLEN'(3));
        for (int i = 0; i < 15; i++) drive(1'b0, OP_R, 12'h000, '0, 1'b1);
        check("instret_reg15", csr_instret, XLEN'(15));
        req(OP_R, A_INSTRET, '0);
        check_resp("r_instret", XLEN'(15), 1'b0);
        drive(1'b1, OP_R, A_INSTRET, '0, 1'b1);
        check_resp("r_instret_retire", XLEN'(15), 1'b0);
        check("instret_after", csr_instret, XLEN'(16));

        // 4. STATUS writes and privilege mode.
        req(OP_RW, A_STATUS, XLEN'(48'h123003));
        check_resp("rw_status", XLEN'(3), 1'b0);
        req(OP_R, A_STATUS, '0);
        check_resp("r_status2", XLEN'(48'h123003), 1'b0);
        check("priv_11", XLEN'(priv_mode), XLEN'(2'b11));
        req(OP_RW, A_STATUS, '0);
        check_resp("rw_status0", XLEN'(48'h123003), 1'b0);
        check("priv_00", XLEN'(priv_mode), XLEN'(2'b00));
        check("status_0", csr_status, '0);

        // 5. Illegal requests.
        req(OP_R, 12'h3FF, '0);
        check_resp("ill_addr", '0, 1'b1);
        idle();
        check("ill_hold_valid", XLEN'(resp_valid), XLEN'(0));
        check("ill_hold_flag", XLEN'(resp_illegal), XLEN'(1));
        cy = csr_cycle;
        req(OP_RW, A_CYCLE, XLEN'(5));
        check_resp("ill_rw_cycle", '0, 1'b1);
        check("cycle_unaffected", csr_cycle, cy + XLEN'(1));
        req(OP_RS, A_INSTRET, XLEN'(1));
        check_resp("ill_rs_instret", '0, 1'b1);
        check("instret_unaffected", csr_instret, XLEN'(16));
        req(OP_R, A_SCRATCH, '0);
        check_resp("scratch_kept", XLEN'(48'h12340), 1'b0);
        req(OP_R, A_STATUS, '0);
        check_resp("status_kept", '0, 1'b0);

        // 6a. CYCLE wrap: deposit all-ones, then let it count.
        force dut.cycle_q = {XLEN{1'b1}};
        #1;
        release dut.cycle_q;
        check("cycle_deposit", csr_cycle, {XLEN{1'b1}});
        req(OP_R, A_CYCLE, '0);
        check_resp("r_cycle_max", {XLEN{1'b1}}, 1'b0);
        check("cycle_wrapped", csr_cycle, '0);
        req(OP_R, A_CYCLE, '0);
        check_resp("r_cycle_zero", '0, 1'b0);

        // 6b. Reset coincident with an RW SCRATCH request is dropped.
        req(OP_RW, A_STATUS, XLEN'(48'h1));
        resetn = 1'b0;
        req(OP_RW, A_SCRATCH, XLEN'(48'hABCDE));
        check("rst2_resp_valid", XLEN'(resp_valid), XLEN'(0));
        check("rst2_rdata", resp_rdata, '0);
        check("rst2_status", csr_status, XLEN'(3));
        check("rst2_cycle", csr_cycle, '0);
        resetn = 1'b1;
        idle();
        check("rst2_idle_valid", XLEN'(resp_valid), XLEN'(0));
        req(OP_R, A_SCRATCH, '0);
        check_resp("rst2_scratch", '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
